// File: rtl/operand_fold_pkg.sv
// Shared types, mode encodings and the fold operation for operand_fold_seq.
package operand_fold_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCompute,
        StDone
    } state_e;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_MAX = 2'b11;

    // Folds run at this fixed width; callers zero-extend in and truncate out.
    localparam int unsigned FOLD_W = 32;

    function automatic logic [FOLD_W-1:0] fold(input logic [1:0]        mode,
                                               input logic [FOLD_W-1:0] acc,
                                               input logic [FOLD_W-1:0] op);
        logic [FOLD_W-1:0] res;
        case (mode)
            MODE_ADD: res = acc + op;
            MODE_SUB: res = acc - op;
            MODE_XOR: res = acc ^ op;
            default:  res = (acc > op) ? acc : op;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/operand_fold_seq_btn_sync.sv
// Two-flop synchroniser with rising-edge detect; one pulse per clean press.
module btn_sync_edge (
    input  logic CLK,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    logic [2:0] sync_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn};
        end
    end

    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/operand_fold_seq.sv
// Keyboard operand entry: captures NUM_OPS operands and folds them sequentially.
module operand_fold_seq
    import operand_fold_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_OPS   = 2,
    parameter int unsigned OUT_WIDTH = WIDTH + $clog2(NUM_OPS)
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           key_data,
    input  logic                       next,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    output logic [OUT_WIDTH-1:0]       disp,
    output logic [$clog2(NUM_OPS)-1:0] op_idx,
    output logic                       done
);

    localparam int unsigned IDX_W = $clog2(NUM_OPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OPS - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     op_q [NUM_OPS];
    logic [WIDTH-1:0]     op_d [NUM_OPS];
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] disp_q, disp_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic                 done_q, done_d;
    logic                 next_pulse;

    btn_sync_edge u_next_sync (
        .CLK     (CLK),
        .reset_n (reset_n),
        .btn     (next),
        .pulse   (next_pulse)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            disp_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ADD;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            disp_q  <= disp_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_OPS; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        disp_d  = disp_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = done_q;
        op_d    = op_q;

        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            disp_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
            mode_d  = MODE_ADD;
            done_d  = 1'b0;
            for (int i = 0; i < NUM_OPS; i++) begin
                op_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCapture;
                    idx_d   = '0;
                end
                StCapture: begin
                    disp_d = OUT_WIDTH'(key_data);
                    if (next_pulse) begin
                        op_d[idx_q] = key_data;
                        if (idx_q == LAST) begin
                            state_d = StCompute;
                            cnt_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    // cnt_q == 0 is the entry cycle: latch mode, seed with op[0].
                    if (cnt_q == '0) begin
                        mode_d = mode;
                        acc_d  = OUT_WIDTH'(op_q[0]);
                        cnt_d  = IDX_W'(1);
                    end else begin
                        acc_d = OUT_WIDTH'(fold(mode_q, FOLD_W'(acc_q), FOLD_W'(op_q[cnt_q])));
                        if (cnt_q == LAST) begin
                            state_d = StDone;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    disp_d = acc_q;
                    done_d = 1'b1;
                    if (next_pulse) begin
                        state_d = StCapture;
                        idx_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign disp   = disp_q;
    assign op_idx = idx_q;
    assign done   = done_q;

endmodule

// File: tb/tb_operand_fold_seq.sv
// Scoreboard bench for operand_fold_seq with WIDTH=8, NUM_OPS=3, OUT_WIDTH=10.
module tb_operand_fold_seq;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       next = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [9:0] disp;
    logic [1:0] op_idx;
    logic       done;

    int tests = 0;
    int failed = 0;
    logic [9:0] exp_q[$];
    logic done_prev = 1'b0;

    operand_fold_seq #(
        .WIDTH     (8),
        .NUM_OPS   (3),
        .OUT_WIDTH (10)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .key_data (key_data),
        .next     (next),
        .clear    (clear),
        .mode     (mode),
        .disp     (disp),
        .op_idx   (op_idx),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising edge of done must match the oldest expected result.
    initial begin
        forever begin
            @(negedge CLK);
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL result: unexpected done with disp=0x%0h", disp);
                end else begin
                    check("result", 32'(disp), 32'(exp_q.pop_front()));
                end
            end
            done_prev = done;
        end
    end

    task automatic press(input logic [7:0] d, input int hold);
        @(negedge CLK);
        key_data = d;
        next = 1'b1;
        repeat (hold) @(negedge CLK);
        next = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic enter(input logic [7:0] d, input int idx, input int hold);
        check("idx_before", 32'(op_idx), 32'(idx));
        press(d, hold);
        check("disp_live", 32'(disp), 32'(d));
        check("idx_after", 32'(op_idx), 32'(idx + 1));
    endtask

    // Last operand: counts negedges from the rise of next until done appears.
    task automatic press_last(input logic [7:0] d, input logic [9:0] expv,
                              input bit toggle, input bit inject);
        logic [1:0] m0;
        int cnt;
        m0 = mode;
        cnt = 0;
        exp_q.push_back(expv);
        @(negedge CLK);
        key_data = d;
        next = 1'b1;
        while (cnt < 40 && done !== 1'b1) begin
            @(negedge CLK);
            cnt++;
            if (inject && cnt == 2) next = 1'b0;
            if (inject && cnt == 3) next = 1'b1;
            if (toggle && cnt >= 4) mode = 2'(cnt);
        end
        check("latency", 32'(cnt), 32'd7);
        next = 1'b0;
        mode = m0;
        repeat (3) @(negedge CLK);
        check("done_held", 32'(done), 32'd1);
        check("idx_hold", 32'(op_idx), 32'd2);
        check("disp_held", 32'(disp), 32'(expv));
    endtask

    task automatic restart();
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        check("clr_disp", 32'(disp), 32'd0);
        check("clr_idx", 32'(op_idx), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_disp", 32'(disp), 32'd0);
        check("rst_idx", 32'(op_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);

        // Add 0x10+0x20+0x30
        mode = 2'b00;
        enter(8'h10, 0, 3);
        enter(8'h20, 1, 3);
        press_last(8'h30, 10'h060, 1'b0, 1'b0);

        // Leave DONE with a press, then sub with a press injected during COMPUTE
        press(8'h00, 3);
        check("exit_done", 32'(done), 32'd0);
        check("exit_idx", 32'(op_idx), 32'd0);
        mode = 2'b01;
        enter(8'h05, 0, 3);
        enter(8'h07, 1, 3);
        press_last(8'h01, 10'h3FD, 1'b0, 1'b1);

        // Add overflow into the extra bits
        restart();
        mode = 2'b00;
        enter(8'hFF, 0, 3);
        enter(8'hFF, 1, 3);
        press_last(8'hFF, 10'h2FD, 1'b0, 1'b0);

        // Xor, first press held for 50 cycles
        restart();
        mode = 2'b10;
        enter(8'hA5, 0, 50);
        enter(8'h0F, 1, 3);
        press_last(8'hFF, 10'h055, 1'b0, 1'b0);

        // Max, mode toggled during COMPUTE
        restart();
        mode = 2'b11;
        enter(8'h12, 0, 3);
        enter(8'h80, 1, 3);
        press_last(8'h7F, 10'h080, 1'b1, 1'b0);

        // Clear coincident with the third pulse
        restart();
        mode = 2'b00;
        enter(8'h01, 0, 3);
        enter(8'h02, 1, 3);
        @(negedge CLK);
        key_data = 8'h03;
        next = 1'b1;
        repeat (2) @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        check("cp_disp", 32'(disp), 32'd0);
        check("cp_idx", 32'(op_idx), 32'd0);
        check("cp_done", 32'(done), 32'd0);
        next = 1'b0;
        repeat (10) @(negedge CLK);
        check("cp_nodone", 32'(done), 32'd0);
        check("cp_idx_late", 32'(op_idx), 32'd0);

        // Asynchronous reset mid-capture, then a fresh sequence
        restart();
        enter(8'h33, 0, 3);
        check("pre_rst_disp", 32'(disp), 32'h33);
        @(negedge CLK);
        #2 reset_n = 1'b0;
        #1;
        check("arst_disp", 32'(disp), 32'd0);
        check("arst_idx", 32'(op_idx), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        enter(8'h40, 0, 3);
        enter(8'h41, 1, 3);
        press_last(8'h42, 10'h0C3, 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
